// File: rtl/pin_lock_pkg.sv
// Shared state encoding, key codes and field widths for the PIN lock controller.
package pin_lock_pkg;

  localparam int unsigned KEY_W    = 4;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned FAIL_W   = 4;
  localparam int unsigned REMAIN_W = 8;
  localparam int unsigned STATE_W  = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_LOCKED   = 3'd0,
    ST_UNLOCKED = 3'd1,
    ST_CHANGE   = 3'd2,
    ST_LOCKOUT  = 3'd3
  } state_e;

  localparam logic [KEY_W-1:0] KEY_ENTER  = 4'hA;
  localparam logic [KEY_W-1:0] KEY_CLEAR  = 4'hB;
  localparam logic [KEY_W-1:0] KEY_CHANGE = 4'hC;
  localparam logic [KEY_W-1:0] KEY_LOCK   = 4'hD;
  localparam logic [KEY_W-1:0] KEY_BLANK  = 4'hF;

  function automatic logic is_digit(input logic [KEY_W-1:0] key);
    return key <= 4'd9;
  endfunction

endpackage

// File: rtl/pin_lock_ctrl_if.sv
// Keypad/timebase inputs and status outputs of the PIN lock controller.
interface pin_lock_ctrl_if
  import pin_lock_pkg::*;
#(
  parameter int unsigned DIGITS = 4
);
  logic                  key_valid;
  logic [KEY_W-1:0]      key_code;
  logic                  tick;
  logic [4*DIGITS-1:0]   entry;
  logic [CNT_W-1:0]      digit_cnt;
  logic                  unlocked;
  logic                  locked_out;
  logic [FAIL_W-1:0]     fail_cnt;
  logic [REMAIN_W-1:0]   remain;
  logic [STATE_W-1:0]    state;

  modport master (
    output key_valid, key_code, tick,
    input  entry, digit_cnt, unlocked, locked_out, fail_cnt, remain, state
  );

  modport slave (
    input  key_valid, key_code, tick,
    output entry, digit_cnt, unlocked, locked_out, fail_cnt, remain, state
  );
endinterface

// File: rtl/pin_entry_buf.sv
// Digit entry shift register: newest digit in the low nibble, blank nibbles read 4'hF.
module pin_entry_buf
  import pin_lock_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                shift,
  input  logic                clr,
  input  logic [KEY_W-1:0]    digit,
  output logic [4*DIGITS-1:0] entry,
  output logic [CNT_W-1:0]    cnt,
  output logic                full_c
);

  assign full_c = (cnt == CNT_W'(DIGITS));

  // Clear has priority so an enter/transition never keeps a stale digit.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      entry <= {DIGITS{KEY_BLANK}};
      cnt   <= '0;
    end else if (shift && !full_c) begin
      entry <= {entry[4*DIGITS-5:0], digit};
      cnt   <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pin_lock_ctrl.sv
// PIN lock controller: keypad entry, unlock/lock, failed-try lockout.
// Optional PIN_LOCK_CHANGE_EN adds the CHANGE state and a writable stored PIN.
module pin_lock_ctrl
  import pin_lock_pkg::*;
#(
  parameter int unsigned         DIGITS        = 4,
  parameter logic [4*DIGITS-1:0] INIT_PIN      = 16'h1234,
  parameter int unsigned         MAX_TRIES     = 3,
  parameter int unsigned         LOCKOUT_TICKS = 10
) (
  input  logic           clk,
  input  logic           rst,
  pin_lock_ctrl_if.slave bus
);

  localparam int unsigned         W           = 4 * DIGITS;
  localparam logic [FAIL_W-1:0]   FAIL_MAX    = FAIL_W'(MAX_TRIES);
  localparam logic [REMAIN_W-1:0] REMAIN_INIT = REMAIN_W'(LOCKOUT_TICKS);

  state_e              state_q, state_d;
  logic [FAIL_W-1:0]   fail_q, fail_d;
  logic [REMAIN_W-1:0] remain_q, remain_d;
  logic                unlocked_q, unlocked_d;
  logic                locked_out_q, locked_out_d;
  logic                shift, clr, full_c;
  logic [W-1:0]        entry;
  logic [CNT_W-1:0]    cnt;
  logic [W-1:0]        pin;

`ifdef PIN_LOCK_CHANGE_EN
  logic [W-1:0] pin_q, pin_d;
  assign pin = pin_q;
`else
  assign pin = INIT_PIN;
`endif

  pin_entry_buf #(.DIGITS(DIGITS)) u_buf (
    .clk    (clk),
    .rst    (rst),
    .shift  (shift),
    .clr    (clr),
    .digit  (bus.key_code),
    .entry  (entry),
    .cnt    (cnt),
    .full_c (full_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_LOCKED;
      fail_q       <= '0;
      remain_q     <= '0;
      unlocked_q   <= 1'b0;
      locked_out_q <= 1'b0;
`ifdef PIN_LOCK_CHANGE_EN
      pin_q        <= INIT_PIN;
`endif
    end else begin
      state_q      <= state_d;
      fail_q       <= fail_d;
      remain_q     <= remain_d;
      unlocked_q   <= unlocked_d;
      locked_out_q <= locked_out_d;
`ifdef PIN_LOCK_CHANGE_EN
      pin_q        <= pin_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    fail_d   = fail_q;
    remain_d = remain_q;
    shift    = 1'b0;
    clr      = 1'b0;
`ifdef PIN_LOCK_CHANGE_EN
    pin_d    = pin_q;
`endif
    case (state_q)
      ST_LOCKED: begin
        if (bus.key_valid) begin
          if (is_digit(bus.key_code)) begin
            shift = 1'b1;
          end else if (bus.key_code == KEY_CLEAR) begin
            clr = 1'b1;
          end else if (bus.key_code == KEY_ENTER) begin
            clr = 1'b1;
            if (full_c && entry == pin) begin
              state_d = ST_UNLOCKED;
              fail_d  = '0;
            end else if (fail_q < FAIL_MAX) begin
              fail_d = fail_q + FAIL_W'(1);
              if (fail_q + FAIL_W'(1) == FAIL_MAX) begin
                state_d  = ST_LOCKOUT;
                remain_d = REMAIN_INIT;
              end
            end
          end
        end
      end
      ST_UNLOCKED: begin
        if (bus.key_valid) begin
          if (bus.key_code == KEY_LOCK) begin
            state_d = ST_LOCKED;
            clr     = 1'b1;
          end
`ifdef PIN_LOCK_CHANGE_EN
          else if (bus.key_code == KEY_CHANGE) begin
            state_d = ST_CHANGE;
            clr     = 1'b1;
          end
`endif
        end
      end
`ifdef PIN_LOCK_CHANGE_EN
      ST_CHANGE: begin
        if (bus.key_valid) begin
          if (is_digit(bus.key_code)) begin
            shift = 1'b1;
          end else if (bus.key_code == KEY_CLEAR) begin
            clr = 1'b1;
          end else if (bus.key_code == KEY_ENTER && full_c) begin
            pin_d   = entry;
            state_d = ST_UNLOCKED;
            clr     = 1'b1;
          end else if (bus.key_code == KEY_LOCK) begin
            state_d = ST_LOCKED;
            clr     = 1'b1;
          end
        end
      end
`endif
      ST_LOCKOUT: begin
        // Keys are ignored here; only the timebase advances the lockout.
        if (bus.tick) begin
          if (remain_q <= REMAIN_W'(1)) begin
            state_d  = ST_LOCKED;
            remain_d = '0;
            fail_d   = '0;
            clr      = 1'b1;
          end else begin
            remain_d = remain_q - REMAIN_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_LOCKED;
        clr     = 1'b1;
      end
    endcase
    unlocked_d   = (state_d == ST_UNLOCKED) || (state_d == ST_CHANGE);
    locked_out_d = (state_d == ST_LOCKOUT);
  end

  assign bus.entry      = entry;
  assign bus.digit_cnt  = cnt;
  assign bus.unlocked   = unlocked_q;
  assign bus.locked_out = locked_out_q;
  assign bus.fail_cnt   = fail_q;
  assign bus.remain     = remain_q;
  assign bus.state      = STATE_W'(state_q);

endmodule

// File: tb/tb_pin_lock_ctrl.sv
// Self-checking bench for pin_lock_ctrl: vector table plus hand-written corner sequences.
module tb_pin_lock_ctrl;
  import pin_lock_pkg::*;

  localparam int unsigned DIGITS = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pin_lock_ctrl_if #(.DIGITS(DIGITS)) bus ();

  pin_lock_ctrl #(
    .DIGITS        (DIGITS),
    .INIT_PIN      (16'h1234),
    .MAX_TRIES     (3),
    .LOCKOUT_TICKS (5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        rst;
    logic        kv;
    logic [3:0]  kc;
    logic        tk;
    logic [2:0]  st;
    logic [15:0] ent;
    logic [3:0]  cnt;
    logic [3:0]  fail;
    logic [7:0]  rem;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   step_no = 0;

  function automatic vec_t v(input logic r, input logic kv, input logic [3:0] kc, input logic tk,
                             input logic [2:0] st, input logic [15:0] ent, input logic [3:0] cnt,
                             input logic [3:0] fail, input logic [7:0] rem);
    vec_t x;
    x.rst = r; x.kv = kv; x.kc = kc; x.tk = tk;
    x.st = st; x.ent = ent; x.cnt = cnt; x.fail = fail; x.rem = rem;
    return x;
  endfunction

  function automatic vec_t k(input logic [3:0] kc, input logic [2:0] st, input logic [15:0] ent,
                             input logic [3:0] cnt, input logic [3:0] fail, input logic [7:0] rem);
    return v(1'b0, 1'b1, kc, 1'b0, st, ent, cnt, fail, rem);
  endfunction

  function automatic vec_t t(input logic [2:0] st, input logic [15:0] ent, input logic [3:0] cnt,
                             input logic [3:0] fail, input logic [7:0] rem);
    return v(1'b0, 1'b0, 4'h0, 1'b1, st, ent, cnt, fail, rem);
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, step_no, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare after the edge.
  task automatic apply(input vec_t x);
    vec_t e;
    @(negedge clk);
    rst           = x.rst;
    bus.key_valid = x.kv;
    bus.key_code  = x.kc;
    bus.tick      = x.tk;
    sb.push_back(x);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    step_no++;
    chk("state",      16'(bus.state),      16'(e.st));
    chk("entry",      bus.entry,           e.ent);
    chk("digit_cnt",  16'(bus.digit_cnt),  16'(e.cnt));
    chk("fail_cnt",   16'(bus.fail_cnt),   16'(e.fail));
    chk("remain",     16'(bus.remain),     16'(e.rem));
    chk("unlocked",   16'(bus.unlocked),   16'((e.st == 3'd1) || (e.st == 3'd2)));
    chk("locked_out", 16'(bus.locked_out), 16'(e.st == 3'd3));
  endtask

  // Four digit keys with the expected display built by shifting in each digit.
  task automatic key_seq(input logic [15:0] digs, input logic [2:0] st, input logic [3:0] fail);
    logic [15:0] e;
    logic [3:0]  d;
    e = 16'hFFFF;
    for (int i = 0; i < 4; i++) begin
      d = digs[15-4*i -: 4];
      e = {e[11:0], d};
      apply(k(d, st, e, 4'(i + 1), fail, 8'd0));
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.key_valid = 1'b0;
    bus.key_code  = 4'h0;
    bus.tick      = 1'b0;

    tbl.push_back(v(1'b1, 1'b0, 4'h0, 1'b0, 3'd0, 16'hFFFF, 4'd0, 4'd0, 8'd0));
    // Correct PIN, with tick and extra keys ignored when full
    tbl.push_back(k(4'h1, 3'd0, 16'hFFF1, 4'd1, 4'd0, 8'd0));
    tbl.push_back(k(4'h2, 3'd0, 16'hFF12, 4'd2, 4'd0, 8'd0));
    tbl.push_back(k(4'h3, 3'd0, 16'hF123, 4'd3, 4'd0, 8'd0));
    tbl.push_back(k(4'h4, 3'd0, 16'h1234, 4'd4, 4'd0, 8'd0));
    tbl.push_back(t(3'd0, 16'h1234, 4'd4, 4'd0, 8'd0));
    tbl.push_back(k(4'h5, 3'd0, 16'h1234, 4'd4, 4'd0, 8'd0));
    tbl.push_back(k(4'hE, 3'd0, 16'h1234, 4'd4, 4'd0, 8'd0));
    tbl.push_back(k(4'hA, 3'd1, 16'hFFFF, 4'd0, 4'd0, 8'd0));
    tbl.push_back(k(4'h1, 3'd1, 16'hFFFF, 4'd0, 4'd0, 8'd0));
    tbl.push_back(k(4'hA, 3'd1, 16'hFFFF, 4'd0, 4'd0, 8'd0));
    tbl.push_back(k(4'hB, 3'd1, 16'hFFFF, 4'd0, 4'd0, 8'd0));
    tbl.push_back(k(4'hD, 3'd0, 16'hFFFF, 4'd0, 4'd0, 8'd0));
    // Overlong entry then clear
    tbl.push_back(k(4'h1, 3'd0, 16'hFFF1, 4'd1, 4'd0, 8'd0));
    tbl.push_back(k(4'h2, 3'd0, 16'hFF12, 4'd2, 4'd0, 8'd0));
    tbl.push_back(k(4'h3, 3'd0, 16'hF123, 4'd3, 4'd0, 8'd0));
    tbl.push_back(k(4'h4, 3'd0, 16'h1234, 4'd4, 4'd0, 8'd0));
    tbl.push_back(k(4'h5, 3'd0, 16'h1234, 4'd4, 4'd0, 8'd0));
    tbl.push_back(k(4'h6, 3'd0, 16'h1234, 4'd4, 4'd0, 8'd0));
    tbl.push_back(k(4'hB, 3'd0, 16'hFFFF, 4'd0, 4'd0, 8'd0));
    // Short entry counts as a failure
    tbl.push_back(k(4'h1, 3'd0, 16'hFFF1, 4'd1, 4'd0, 8'd0));
    tbl.push_back(k(4'h2, 3'd0, 16'hFF12, 4'd2, 4'd0, 8'd0));
    tbl.push_back(k(4'hA, 3'd0, 16'hFFFF, 4'd0, 4'd1, 8'd0));
    // Two wrong PINs reach the lockout
    tbl.push_back(k(4'h1, 3'd0, 16'hFFF1, 4'd1, 4'd1, 8'd0));
    tbl.push_back(k(4'h2, 3'd0, 16'hFF12, 4'd2, 4'd1, 8'd0));
    tbl.push_back(k(4'h3, 3'd0, 16'hF123, 4'd3, 4'd1, 8'd0));
    tbl.push_back(k(4'h5, 3'd0, 16'h1235, 4'd4, 4'd1, 8'd0));
    tbl.push_back(k(4'hA, 3'd0, 16'hFFFF, 4'd0, 4'd2, 8'd0));
    tbl.push_back(k(4'h1, 3'd0, 16'hFFF1, 4'd1, 4'd2, 8'd0));
    tbl.push_back(k(4'h2, 3'd0, 16'hFF12, 4'd2, 4'd2, 8'd0));
    tbl.push_back(k(4'h3, 3'd0, 16'hF123, 4'd3, 4'd2, 8'd0));
    tbl.push_back(k(4'h5, 3'd0, 16'h1235, 4'd4, 4'd2, 8'd0));
    tbl.push_back(k(4'hA, 3'd3, 16'hFFFF, 4'd0, 4'd3, 8'd5));
    // Lockout countdown; keys (even with a simultaneous tick) are ignored
    tbl.push_back(k(4'h1, 3'd3, 16'hFFFF, 4'd0, 4'd3, 8'd5));
    tbl.push_back(t(3'd3, 16'hFFFF, 4'd0, 4'd3, 8'd4));
    tbl.push_back(v(1'b0, 1'b1, 4'hA, 1'b1, 3'd3, 16'hFFFF, 4'd0, 4'd3, 8'd3));
    tbl.push_back(k(4'hB, 3'd3, 16'hFFFF, 4'd0, 4'd3, 8'd3));
    tbl.push_back(t(3'd3, 16'hFFFF, 4'd0, 4'd3, 8'd2));
    tbl.push_back(t(3'd3, 16'hFFFF, 4'd0, 4'd3, 8'd1));
    tbl.push_back(t(3'd0, 16'hFFFF, 4'd0, 4'd0, 8'd0));
    tbl.push_back(k(4'h1, 3'd0, 16'hFFF1, 4'd1, 4'd0, 8'd0));
    tbl.push_back(k(4'h2, 3'd0, 16'hFF12, 4'd2, 4'd0, 8'd0));
    tbl.push_back(k(4'h3, 3'd0, 16'hF123, 4'd3, 4'd0, 8'd0));
    tbl.push_back(k(4'h4, 3'd0, 16'h1234, 4'd4, 4'd0, 8'd0));
    tbl.push_back(k(4'hA, 3'd1, 16'hFFFF, 4'd0, 4'd0, 8'd0));
    tbl.push_back(k(4'hD, 3'd0, 16'hFFFF, 4'd0, 4'd0, 8'd0));

    foreach (tbl[i]) apply(tbl[i]);

`ifdef PIN_LOCK_CHANGE_EN
    // Change PIN to 9876, exercising short enter and full-buffer ignore
    key_seq(16'h1234, 3'd0, 4'd0);
    apply(k(4'hA, 3'd1, 16'hFFFF, 4'd0, 4'd0, 8'd0));
    apply(k(4'hC, 3'd2, 16'hFFFF, 4'd0, 4'd0, 8'd0));
    apply(k(4'h9, 3'd2, 16'hFFF9, 4'd1, 4'd0, 8'd0));
    apply(k(4'h8, 3'd2, 16'hFF98, 4'd2, 4'd0, 8'd0));
    apply(k(4'h7, 3'd2, 16'hF987, 4'd3, 4'd0, 8'd0));
    apply(k(4'hA, 3'd2, 16'hF987, 4'd3, 4'd0, 8'd0));
    apply(k(4'h6, 3'd2, 16'h9876, 4'd4, 4'd0, 8'd0));
    apply(k(4'h5, 3'd2, 16'h9876, 4'd4, 4'd0, 8'd0));
    apply(k(4'hA, 3'd1, 16'hFFFF, 4'd0, 4'd0, 8'd0));
    apply(k(4'hD, 3'd0, 16'hFFFF, 4'd0, 4'd0, 8'd0));
    key_seq(16'h9876, 3'd0, 4'd0);
    apply(k(4'hA, 3'd1, 16'hFFFF, 4'd0, 4'd0, 8'd0));
    apply(k(4'hD, 3'd0, 16'hFFFF, 4'd0, 4'd0, 8'd0));
    key_seq(16'h1234, 3'd0, 4'd0);
    apply(k(4'hA, 3'd0, 16'hFFFF, 4'd0, 4'd1, 8'd0));
    // Abort a change with D: stored PIN stays 9876
    key_seq(16'h9876, 3'd0, 4'd1);
    apply(k(4'hA, 3'd1, 16'hFFFF, 4'd0, 4'd0, 8'd0));
    apply(k(4'hC, 3'd2, 16'hFFFF, 4'd0, 4'd0, 8'd0));
    key_seq(16'h1111, 3'd2, 4'd0);
    apply(k(4'hD, 3'd0, 16'hFFFF, 4'd0, 4'd0, 8'd0));
    key_seq(16'h9876, 3'd0, 4'd0);
    apply(k(4'hA, 3'd1, 16'hFFFF, 4'd0, 4'd0, 8'd0));
    apply(k(4'hD, 3'd0, 16'hFFFF, 4'd0, 4'd0, 8'd0));
`else
    // C has no meaning without the change feature
    key_seq(16'h1234, 3'd0, 4'd0);
    apply(k(4'hA, 3'd1, 16'hFFFF, 4'd0, 4'd0, 8'd0));
    apply(k(4'hC, 3'd1, 16'hFFFF, 4'd0, 4'd0, 8'd0));
    apply(k(4'hD, 3'd0, 16'hFFFF, 4'd0, 4'd0, 8'd0));
`endif

    // Reset in the middle of a lockout (remain 3) restores the power-on state
    key_seq(16'h1235, 3'd0, 4'd0);
    apply(k(4'hA, 3'd0, 16'hFFFF, 4'd0, 4'd1, 8'd0));
    key_seq(16'h1235, 3'd0, 4'd1);
    apply(k(4'hA, 3'd0, 16'hFFFF, 4'd0, 4'd2, 8'd0));
    key_seq(16'h1235, 3'd0, 4'd2);
    apply(k(4'hA, 3'd3, 16'hFFFF, 4'd0, 4'd3, 8'd5));
    apply(t(3'd3, 16'hFFFF, 4'd0, 4'd3, 8'd4));
    apply(t(3'd3, 16'hFFFF, 4'd0, 4'd3, 8'd3));
    apply(v(1'b1, 1'b1, 4'hA, 1'b1, 3'd0, 16'hFFFF, 4'd0, 4'd0, 8'd0));
    key_seq(16'h1234, 3'd0, 4'd0);
    apply(k(4'hA, 3'd1, 16'hFFFF, 4'd0, 4'd0, 8'd0));
    apply(k(4'hD, 3'd0, 16'hFFFF, 4'd0, 4'd0, 8'd0));

    @(negedge clk);
    bus.key_valid = 1'b0;
    bus.tick      = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pin_lock_ctrl.md
PIN_LOCK_CTRL -- requirements
Module: pin_lock_ctrl

Interface
REQ-001 DIGITS, 4, PIN length in BCD digits (2..8) SHALL be a parameter.
REQ-002 INIT_PIN, 16'h1234, reset PIN of width 4*DIGITS, most significant nibble entered first, SHALL be a parameter.
REQ-003 MAX_TRIES, 3, consecutive failed entries before lockout (1..15), SHALL be a parameter.
REQ-004 LOCKOUT_TICKS, 10, lockout duration in tick pulses (1..255), SHALL be a parameter.
REQ-005 clk  in  1  system clock; all logic on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 key_valid  in  1  one-cycle pulse qualifying key_code.
REQ-008 key_code  in  4  key: 0-9 digit, A enter, B clear, C change-PIN, D lock; E/F ignored.
REQ-009 tick  in  1  one-cycle timebase enable pulse from the clock divider.
REQ-010 entry  out  4*DIGITS  entered digits for display, newest in low nibble, blank nibble = 4'hF.
REQ-011 digit_cnt  out  4  digits currently entered.
REQ-012 unlocked  out  1  high in UNLOCKED and CHANGE.
REQ-013 locked_out  out  1  high in LOCKOUT.
REQ-014 fail_cnt  out  4  consecutive failures.
REQ-015 remain  out  8  lockout ticks remaining.
REQ-016 state  out  3  current FSM state code.

Function
REQ-017 FSM states SHALL be LOCKED, UNLOCKED, CHANGE, LOCKOUT; all registered outputs update on the clk edge where key_valid/tick is sampled (visible next cycle).
REQ-018 Digit key in LOCKED or CHANGE with digit_cnt<DIGITS SHALL shift entry left one nibble, insert key in low nibble, increment digit_cnt; at digit_cnt==DIGITS further digits are ignored.
REQ-019 Clear key in LOCKED or CHANGE SHALL set entry to all 4'hF and digit_cnt to 0.
REQ-020 Enter in LOCKED with digit_cnt==DIGITS and entry==stored PIN SHALL go to UNLOCKED and zero fail_cnt.
REQ-021 Enter in LOCKED otherwise (mismatch or short entry) SHALL increment fail_cnt; if new value equals MAX_TRIES, go to LOCKOUT with remain=LOCKOUT_TICKS.
REQ-022 Every enter in LOCKED SHALL clear entry and digit_cnt.
REQ-023 In LOCKOUT all keys SHALL be ignored; each tick decrements remain; tick with remain==1 SHALL go to LOCKED, remain=0, fail_cnt=0.
REQ-024 In UNLOCKED, D SHALL go to LOCKED; digits, clear and enter SHALL be ignored.
REQ-025 In CHANGE, enter with digit_cnt==DIGITS SHALL load entry into stored PIN and go to UNLOCKED; enter with digit_cnt<DIGITS SHALL be ignored; D SHALL abort to LOCKED with stored PIN unchanged.
REQ-026 Entry SHALL be cleared on every transition into LOCKED, UNLOCKED or CHANGE.
REQ-027 tick outside LOCKOUT SHALL have no effect; key_valid and tick in the same LOCKOUT cycle: tick processed, key ignored.
REQ-028 fail_cnt SHALL saturate at MAX_TRIES.

Reset
REQ-029 rst SHALL win over all inputs: state LOCKED, stored PIN=INIT_PIN, entry all 4'hF, digit_cnt=0, fail_cnt=0, remain=0, unlocked=0, locked_out=0, including mid-lockout or mid-change.

Configuration
REQ-030 With PIN_LOCK_CHANGE_EN defined, key C in UNLOCKED SHALL go to CHANGE and stored PIN is a register.
REQ-031 Without PIN_LOCK_CHANGE_EN, CHANGE SHALL not exist, key C SHALL be ignored, and stored PIN SHALL be the constant INIT_PIN.

Structure
REQ-032 Package pin_lock_pkg SHALL hold the state encoding (LOCKED=0, UNLOCKED=1, CHANGE=2, LOCKOUT=3) and key-code constants (ENTER=A, CLEAR=B, CHANGE=C, LOCK=D, BLANK=F).
REQ-033 Sub-module pin_entry_buf SHALL implement the digit shift register and digit_cnt (shift, clear, full).

Verification (DIGITS=4, INIT_PIN=16'h1234, MAX_TRIES=3, LOCKOUT_TICKS=5)
REQ-034 Keys 1,2,3,4,A -> unlocked=1, state=1, fail_cnt=0, entry=16'hFFFF.
REQ-035 Keys 1,2,3,5,A three times -> fail_cnt 1,2 then state=3, remain=5; keys during lockout ignored; 5 ticks -> state=0, fail_cnt=0.
REQ-036 Keys 1,2,3,4,5,6 -> entry=16'h1234, digit_cnt=4; B -> entry=16'hFFFF, digit_cnt=0.
REQ-037 With PIN_LOCK_CHANGE_EN: unlock, C, 9,8,7,6,A, D, then 9,8,7,6,A -> unlocked=1; old 1234 -> fail_cnt=1.
REQ-038 rst asserted in LOCKOUT with remain=3 -> next cycle state=0, remain=0, fail_cnt=0, PIN back to 1234.
